// File: rtl/mole_field_controller.sv
// Whack-a-mole field controller: game FSM, tick divider, LFSR mole spawner, hit/miss scoring.
// Optional build macro MISS_PENALTY_EN: a miss costs one point (score saturates at 0).
`timescale 1ns/1ps
module mole_field_controller #(
    parameter int          NUM_MOLES  = 5,
    parameter int          SCORE_W    = 8,
    parameter int          TICK_DIV   = 50000000,
    parameter int          GAME_TICKS = 30,
    parameter int          MOLE_LIFE  = 3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         hit_valid,
    input  logic [$clog2(NUM_MOLES)-1:0] hit_idx,
    output logic [1:0]                   state,
    output logic [NUM_MOLES-1:0]         moles,
    output logic [SCORE_W-1:0]           score,
    output logic [5:0]                   time_left,
    output logic                         mole_hit,
    output logic                         mole_miss
);

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Galois step for x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ 16'hB400;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    state_t                        state_r, state_n_s;
    logic [NUM_MOLES-1:0]          moles_r, moles_n_s, play_moles_s;
    logic [NUM_MOLES-1:0][3:0]     life_r, life_n_s, play_life_s;
    logic [SCORE_W-1:0]            score_r, score_n_s;
    logic [5:0]                    time_left_r, time_n_s;
    logic [DIV_W-1:0]              div_r, div_n_s;
    logic [15:0]                   lfsr_r;
    logic                          mole_hit_r, mole_miss_r;

    logic                          tick_s, final_tick_s, idx_ok_s, hit_s, miss_s;
    logic [IDX_W-1:0]              target_s;

    assign tick_s       = (state_r == ST_PLAY) && (div_r == DIV_W'(TICK_DIV - 1));
    assign final_tick_s = tick_s && (time_left_r == 6'd1);
    assign idx_ok_s     = (32'(hit_idx) < 32'(NUM_MOLES));
    assign hit_s        = (state_r == ST_PLAY) && hit_valid && idx_ok_s && moles_r[hit_idx];
    assign miss_s       = (state_r == ST_PLAY) && hit_valid && idx_ok_s && !moles_r[hit_idx];
    assign target_s     = IDX_W'(lfsr_r % 16'(NUM_MOLES));

    // Next game state.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_n_s = ST_PLAY;
                else       state_n_s = ST_IDLE;
            end
            ST_PLAY: begin
                if (final_tick_s) state_n_s = ST_OVER;
                else              state_n_s = ST_PLAY;
            end
            ST_OVER: begin
                if (start) state_n_s = ST_PLAY;
                else       state_n_s = ST_OVER;
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // Per-hole update during play: a hit beats spawn/expiry on its own hole.
    always_comb begin
        play_moles_s = moles_r;
        play_life_s  = life_r;
        for (int i = 0; i < NUM_MOLES; i++) begin
            if (hit_s && (hit_idx == IDX_W'(i))) begin
                play_moles_s[i] = 1'b0;
                play_life_s[i]  = 4'd0;
            end else if (tick_s) begin
                if (!moles_r[i]) begin
                    if (target_s == IDX_W'(i)) begin
                        play_moles_s[i] = 1'b1;
                        play_life_s[i]  = 4'(MOLE_LIFE);
                    end else begin
                        play_moles_s[i] = 1'b0;
                        play_life_s[i]  = 4'd0;
                    end
                end else if (life_r[i] == 4'd1) begin
                    play_moles_s[i] = 1'b0;
                    play_life_s[i]  = 4'd0;
                end else begin
                    play_moles_s[i] = 1'b1;
                    play_life_s[i]  = life_r[i] - 4'd1;
                end
            end else begin
                play_moles_s[i] = moles_r[i];
                play_life_s[i]  = life_r[i];
            end
        end
    end

    // Field, score, timer and divider next values.
    always_comb begin
        moles_n_s = moles_r;
        life_n_s  = life_r;
        score_n_s = score_r;
        time_n_s  = time_left_r;
        div_n_s   = div_r;
        case (state_r)
            ST_PLAY: begin
                if (tick_s) div_n_s = {DIV_W{1'b0}};
                else        div_n_s = div_r + DIV_W'(1);

                if (final_tick_s) begin
                    moles_n_s = {NUM_MOLES{1'b0}};
                    life_n_s  = play_life_s;
                end else begin
                    moles_n_s = play_moles_s;
                    life_n_s  = play_life_s;
                end

                if (hit_s) begin
                    if (score_r == SCORE_MAX) score_n_s = score_r;
                    else                      score_n_s = score_r + SCORE_W'(1);
                end else if (miss_s) begin
`ifdef MISS_PENALTY_EN
                    if (score_r == {SCORE_W{1'b0}}) score_n_s = score_r;
                    else                            score_n_s = score_r - SCORE_W'(1);
`else
                    score_n_s = score_r;
`endif
                end else begin
                    score_n_s = score_r;
                end

                if (tick_s) time_n_s = time_left_r - 6'd1;
                else        time_n_s = time_left_r;
            end
            ST_IDLE, ST_OVER: begin
                moles_n_s = {NUM_MOLES{1'b0}};
                if (start) begin
                    life_n_s  = '0;
                    score_n_s = {SCORE_W{1'b0}};
                    time_n_s  = 6'(GAME_TICKS);
                    div_n_s   = {DIV_W{1'b0}};
                end else begin
                    life_n_s  = life_r;
                    score_n_s = score_r;
                    time_n_s  = time_left_r;
                    div_n_s   = div_r;
                end
            end
            default: begin
                moles_n_s = {NUM_MOLES{1'b0}};
                life_n_s  = '0;
            end
        endcase
    end

    // State register and datapath registers; event pulses are one cycle late by construction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            moles_r     <= {NUM_MOLES{1'b0}};
            life_r      <= '0;
            score_r     <= {SCORE_W{1'b0}};
            time_left_r <= 6'(GAME_TICKS);
            div_r       <= {DIV_W{1'b0}};
            lfsr_r      <= SEED;
            mole_hit_r  <= 1'b0;
            mole_miss_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            moles_r     <= moles_n_s;
            life_r      <= life_n_s;
            score_r     <= score_n_s;
            time_left_r <= time_n_s;
            div_r       <= div_n_s;
            lfsr_r      <= lfsr_step(lfsr_r);
            mole_hit_r  <= hit_s;
            mole_miss_r <= miss_s;
        end
    end

    assign state     = state_r;
    assign moles     = moles_r;
    assign score     = score_r;
    assign time_left = time_left_r;
    assign mole_hit  = mole_hit_r;
    assign mole_miss = mole_miss_r;

endmodule

// File: tb/tb_mole_field_controller.sv
// Self-checking bench for mole_field_controller: behavioural game model feeds a scoreboard queue
// that is compared against the DUT outputs every cycle, plus targeted scenario checks.
`timescale 1ns/1ps
module tb_mole_field_controller;

    localparam int N  = 5;
    localparam int SW = 8;
    localparam int TD = 4;
    localparam int GT = 3;
    localparam int ML = 2;
    localparam logic [15:0] SD = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset, start, hit_valid;
    logic [2:0] hit_idx;
    logic [1:0] state;
    logic [N-1:0] moles;
    logic [SW-1:0] score;
    logic [5:0] time_left;
    logic       mole_hit, mole_miss;

    mole_field_controller #(
        .NUM_MOLES(N), .SCORE_W(SW), .TICK_DIV(TD),
        .GAME_TICKS(GT), .MOLE_LIFE(ML), .SEED(SD)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .hit_valid(hit_valid),
        .hit_idx(hit_idx), .state(state), .moles(moles), .score(score),
        .time_left(time_left), .mole_hit(mole_hit), .mole_miss(mole_miss)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]    st;
        logic [N-1:0]  ml;
        logic [SW-1:0] sc;
        logic [5:0]    tl;
        logic          h;
        logic          m;
    } exp_t;

    exp_t sb_q[$];

    int vectors = 0;
    int miscompares = 0;

    // behavioural model of the game, written from the rules rather than the RTL structure
    int           m_state = 0;
    int           m_score = 0;
    int           m_time  = GT;
    int           m_div   = 0;
    int           m_life[N];
    logic [N-1:0] m_moles = '0;
    logic [15:0]  m_lfsr  = SD;

    function automatic int low_bit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int first_empty(input logic [N-1:0] v, input int pref);
        if (!v[pref]) return pref;
        for (int i = 0; i < N; i++) if (!v[i]) return i;
        return -1;
    endfunction

    task automatic step(input logic rst, input logic st, input logic hv, input logic [2:0] idx);
        exp_t e, got;
        int n_state, n_score, n_time, n_div, tgt;
        int n_life[N];
        logic [N-1:0] n_moles;
        logic [15:0] n_lfsr;
        logic tick, n_hit, n_miss;
        n_state = m_state; n_score = m_score; n_time = m_time; n_div = m_div;
        n_moles = m_moles; n_hit = 1'b0; n_miss = 1'b0;
        for (int i = 0; i < N; i++) n_life[i] = m_life[i];
        n_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        if (rst) begin
            n_state = 0; n_score = 0; n_time = GT; n_div = 0; n_moles = '0;
            n_lfsr = SD;
            for (int i = 0; i < N; i++) n_life[i] = 0;
        end else if (m_state != 1) begin
            n_moles = '0;
            if (st) begin
                n_state = 1; n_score = 0; n_time = GT; n_div = 0;
                for (int i = 0; i < N; i++) n_life[i] = 0;
            end
        end else begin
            tick  = (m_div == TD - 1);
            n_div = tick ? 0 : m_div + 1;
            tgt   = int'(m_lfsr) % N;
            if (hv && int'(idx) < N) begin
                if (m_moles[idx]) n_hit = 1'b1;
                else              n_miss = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (n_hit && i == int'(idx)) begin
                    n_moles[i] = 1'b0; n_life[i] = 0;
                end else if (tick) begin
                    if (!m_moles[i] && i == tgt) begin
                        n_moles[i] = 1'b1; n_life[i] = ML;
                    end else if (m_moles[i]) begin
                        n_life[i] = m_life[i] - 1;
                        if (n_life[i] == 0) n_moles[i] = 1'b0;
                    end
                end
            end
            if (n_hit && m_score < (1 << SW) - 1) n_score = m_score + 1;
`ifdef MISS_PENALTY_EN
            if (n_miss && m_score > 0) n_score = m_score - 1;
`endif
            if (tick) begin
                n_time = m_time - 1;
                if (n_time == 0) begin
                    n_state = 2; n_moles = '0;
                end
            end
        end
        e.st = n_state[1:0]; e.ml = n_moles; e.sc = n_score[SW-1:0];
        e.tl = n_time[5:0];  e.h = n_hit;    e.m = n_miss;
        sb_q.push_back(e);
        reset = rst; start = st; hit_valid = hv; hit_idx = idx;
        @(posedge clock);
        #1;
        m_state = n_state; m_score = n_score; m_time = n_time; m_div = n_div;
        m_moles = n_moles; m_lfsr = n_lfsr;
        for (int i = 0; i < N; i++) m_life[i] = n_life[i];
        got = sb_q.pop_front();
        vectors += 6;
        if (state !== got.st) begin
            miscompares++; $display("FAIL sb_state t=%0t got %0d expected %0d", $time, state, got.st);
        end
        if (moles !== got.ml) begin
            miscompares++; $display("FAIL sb_moles t=%0t got %b expected %b", $time, moles, got.ml);
        end
        if (score !== got.sc) begin
            miscompares++; $display("FAIL sb_score t=%0t got %0d expected %0d", $time, score, got.sc);
        end
        if (time_left !== got.tl) begin
            miscompares++; $display("FAIL sb_time_left t=%0t got %0d expected %0d", $time, time_left, got.tl);
        end
        if (mole_hit !== got.h) begin
            miscompares++; $display("FAIL sb_mole_hit t=%0t got %b expected %b", $time, mole_hit, got.h);
        end
        if (mole_miss !== got.m) begin
            miscompares++; $display("FAIL sb_mole_miss t=%0t got %b expected %b", $time, mole_miss, got.m);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic new_game();
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0);
    endtask

    // steps until the model shows a mole up; a timeout is itself a miscompare
    task automatic wait_for_mole(output int hole);
        hole = -1;
        for (int c = 0; c < 4 * TD && m_moles == '0 && m_state == 1; c++) idle();
        hole = low_bit(m_moles);
        vectors++;
        if (hole < 0) begin
            miscompares++; $display("FAIL wait_for_mole got none expected a spawned mole");
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd1);
        vectors++;
        if (state !== 2'd0 || moles !== '0 || score !== '0 || time_left !== 6'd3) begin
            miscompares++;
            $display("FAIL reset_state got st=%0d ml=%b sc=%0d tl=%0d expected 0/0/0/3", state, moles, score, time_left);
        end
        idle();
        idle();
    endtask

    task automatic test_game_length();
        int over_at;
        new_game();
        vectors++;
        if (state !== 2'd1 || time_left !== 6'd3) begin
            miscompares++; $display("FAIL start_play got st=%0d tl=%0d expected 1/3", state, time_left);
        end
        over_at = -1;
        for (int c = 1; c <= 20 && over_at < 0; c++) begin
            idle();
            if (state == 2'd2) over_at = c;
        end
        vectors++;
        if (over_at !== 12 || time_left !== 6'd0) begin
            miscompares++; $display("FAIL game_length got %0d cycles tl=%0d expected 12 cycles tl=0", over_at, time_left);
        end
    endtask

    task automatic test_hit();
        int h;
        new_game();
        wait_for_mole(h);
        if (h >= 0) begin
            step(1'b0, 1'b0, 1'b1, 3'(h));
            vectors++;
            if (moles[h] !== 1'b0 || score !== 8'd1 || mole_hit !== 1'b1) begin
                miscompares++; $display("FAIL hit got ml=%b sc=%0d hit=%b expected bit%0d=0 sc=1 hit=1", moles, score, mole_hit, h);
            end
            idle();
            vectors++;
            if (mole_hit !== 1'b0) begin
                miscompares++; $display("FAIL hit_pulse_width got %b expected 0", mole_hit);
            end
        end
        for (int c = 0; c < 4 * TD && !(m_div == TD - 1 && m_time == 1); c++) idle();
        h = low_bit(m_moles);
        step(1'b0, 1'b0, 1'b1, (h >= 0) ? 3'(h) : 3'd0);
        vectors++;
        if (state !== 2'd2) begin
            miscompares++; $display("FAIL hit_final_tick got st=%0d expected 2", state);
        end
    endtask

    task automatic test_miss();
        int h, e;
        new_game();
        wait_for_mole(h);
        if (h >= 0) step(1'b0, 1'b0, 1'b1, 3'(h));
        e = first_empty(m_moles, 4);
        step(1'b0, 1'b0, 1'b1, 3'(e));
        vectors++;
`ifdef MISS_PENALTY_EN
        if (mole_miss !== 1'b1 || score !== 8'd0) begin
`else
        if (mole_miss !== 1'b1 || score !== 8'd1) begin
`endif
            miscompares++; $display("FAIL miss got miss=%b sc=%0d", mole_miss, score);
        end
        e = first_empty(m_moles, 4);
        step(1'b0, 1'b0, 1'b1, 3'(e));
        vectors++;
`ifdef MISS_PENALTY_EN
        if (mole_miss !== 1'b1 || score !== 8'd0) begin
`else
        if (mole_miss !== 1'b1 || score !== 8'd1) begin
`endif
            miscompares++; $display("FAIL miss_again got miss=%b sc=%0d", mole_miss, score);
        end
    endtask

    task automatic test_ignored_index();
        new_game();
        for (int k = 5; k <= 7; k++) begin
            step(1'b0, 1'b0, 1'b1, 3'(k));
            vectors++;
            if (mole_hit !== 1'b0 || mole_miss !== 1'b0) begin
                miscompares++; $display("FAIL bad_index idx=%0d got hit=%b miss=%b expected 0/0", k, mole_hit, mole_miss);
            end
        end
    endtask

    task automatic test_expiry();
        int h;
        new_game();
        wait_for_mole(h);
        for (int c = 0; c < TD; c++) idle();
        vectors++;
        if (h >= 0 && moles[h] !== 1'b1) begin
            miscompares++; $display("FAIL expiry_alive got %b expected bit%0d set", moles, h);
        end
        for (int c = 0; c < TD; c++) idle();
        vectors++;
        if (h >= 0 && (moles[h] !== 1'b0 || score !== 8'd0)) begin
            miscompares++; $display("FAIL expiry_cleared got ml=%b sc=%0d expected bit%0d=0 sc=0", moles, score, h);
        end
    endtask

    task automatic test_reset_mid_play();
        int h;
        new_game();
        wait_for_mole(h);
        if (h >= 0) step(1'b0, 1'b0, 1'b1, 3'(h));
        step(1'b0, 1'b1, 1'b0, 3'd0);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++; $display("FAIL start_in_play got st=%0d expected 1", state);
        end
        step(1'b1, 1'b1, 1'b1, 3'd0);
        vectors++;
        if (state !== 2'd0 || score !== 8'd0 || moles !== '0 || time_left !== 6'd3) begin
            miscompares++; $display("FAIL reset_mid_play got st=%0d sc=%0d ml=%b tl=%0d expected 0/0/0/3", state, score, moles, time_left);
        end
    endtask

    task automatic test_over();
        int h;
        new_game();
        wait_for_mole(h);
        if (h >= 0) step(1'b0, 1'b0, 1'b1, 3'(h));
        for (int c = 0; c < 4 * GT * TD && m_state != 2; c++) idle();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, 3'(k));
            vectors++;
            if (mole_hit !== 1'b0 || mole_miss !== 1'b0 || state !== 2'd2) begin
                miscompares++; $display("FAIL over_hit idx=%0d got st=%0d hit=%b miss=%b expected 2/0/0", k, state, mole_hit, mole_miss);
            end
        end
        step(1'b0, 1'b1, 1'b0, 3'd0);
        vectors++;
        if (state !== 2'd1 || score !== 8'd0) begin
            miscompares++; $display("FAIL over_restart got st=%0d sc=%0d expected 1/0", state, score);
        end
    endtask

    task automatic test_back_to_back();
        logic rs, st, hv;
        logic [2:0] ix;
        int lb;
        for (int c = 0; c < 400; c++) begin
            rs = ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 7) == 0);
            hv = ($urandom_range(0, 1) == 1);
            lb = low_bit(m_moles);
            if (lb >= 0 && $urandom_range(0, 1) == 1) ix = 3'(lb);
            else                                      ix = 3'($urandom_range(0, 7));
            step(rs, st, hv, ix);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hit_valid = 1'b0; hit_idx = 3'd0;
        for (int i = 0; i < N; i++) m_life[i] = 0;
        test_reset();
        test_game_length();
        test_hit();
        test_miss();
        test_ignored_index();
        test_expiry();
        test_reset_mid_play();
        test_over();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
